// File: rtl/ascon_perm_arbiter.sv
// Round-robin arbiter sharing one Ascon permutation core between NUM_REQ
// requesters. Latches the winner's state and round count, drives the core,
// and returns the permuted state (or an error) with a one-cycle ack.
module ascon_perm_arbiter #(
   parameter int NUM_REQ     = 3,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ*320-1:0] req_state,
   input  logic [NUM_REQ*4-1:0]   req_rounds,
   output logic [NUM_REQ-1:0]     ack,
   output logic [319:0]           rsp_state,
   output logic                   rsp_err,
   output logic                   busy,
   output logic                   perm_start,
   output logic [319:0]           perm_state,
   output logic [3:0]             perm_rounds,
   input  logic [319:0]           perm_out,
   input  logic                   perm_done
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int WD_W  = $clog2(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] grant;
   logic [PTR_W-1:0] win;
   logic [PTR_W-1:0] cand;
   int               arb_idx;
   logic [WD_W-1:0]  watchdog;
   logic [3:0]       win_rounds;
   logic             win_rounds_ok;
   logic             wd_expired;

   // Round-robin search: scan offsets from farthest to nearest so the
   // requester closest to rr_ptr is the last (winning) assignment.
   always_comb begin
      win     = rr_ptr;
      cand    = rr_ptr;
      arb_idx = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         arb_idx = (int'(rr_ptr) + k) % NUM_REQ;
         cand    = PTR_W'(arb_idx);
         if (req[cand]) begin
            win = cand;
         end
      end
   end

   // Winner's round count and its legality (1..12); the watchdog limit.
   always_comb begin
      win_rounds    = req_rounds[win*4 +: 4];
      win_rounds_ok = (win_rounds != 4'd0) && (win_rounds <= 4'd12);
      wd_expired    = (watchdog == WD_W'(TIMEOUT_CYC - 1));
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and control outputs; illegal round counts bypass the core.
   always_comb begin
      state_nxt  = state;
      ack        = '0;
      busy       = (state != S_IDLE);
      perm_start = 1'b0;
      case (state)
         S_IDLE: begin
            if (|req) begin
               state_nxt = win_rounds_ok ? S_LAUNCH : S_RESP;
            end
         end
         S_LAUNCH: begin
            perm_start = 1'b1;
            state_nxt  = S_WAIT;
         end
         S_WAIT: begin
            if (perm_done || wd_expired) begin
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            ack[grant] = 1'b1;
            state_nxt  = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Grant capture, core operands, watchdog, response data and pointer rotation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant       <= '0;
         rr_ptr      <= '0;
         watchdog    <= '0;
         perm_state  <= '0;
         perm_rounds <= '0;
         rsp_state   <= '0;
         rsp_err     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (|req) begin
                  grant       <= win;
                  perm_state  <= req_state[win*320 +: 320];
                  perm_rounds <= win_rounds;
                  if (!win_rounds_ok) begin
                     rsp_state <= '0;
                     rsp_err   <= 1'b1;
                  end
               end
            end
            S_LAUNCH: begin
               watchdog <= '0;
            end
            S_WAIT: begin
               if (perm_done) begin
                  rsp_state <= perm_out;
                  rsp_err   <= 1'b0;
               end else if (wd_expired) begin
                  rsp_state <= '0;
                  rsp_err   <= 1'b1;
               end else begin
                  watchdog <= watchdog + 1'b1;
               end
            end
            S_RESP: begin
               rr_ptr <= (grant == PTR_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
